// File: rtl/pll_cfg_pkg.sv
// Shared definitions for the PLL reconfiguration responder: register addresses,
// power-on counter settings and the sequencer state encoding.
package pll_cfg_pkg;

    localparam logic [5:0] ADDR_MODE   = 6'd0;
    localparam logic [5:0] ADDR_STATUS = 6'd1;
    localparam logic [5:0] ADDR_START  = 6'd2;
    localparam logic [5:0] ADDR_N      = 6'd3;
    localparam logic [5:0] ADDR_M      = 6'd4;
    localparam logic [5:0] ADDR_C0     = 6'd5;
    localparam logic [5:0] ADDR_MFRAC  = 6'd7;

    localparam logic [31:0] N_RESET     = 32'h0001_0000;
    localparam logic [31:0] M_RESET     = 32'h0000_0404;
    localparam logic [31:0] C0_RESET    = 32'h0000_0505;
    localparam logic [31:0] MFRAC_RESET = 32'h9745_BF27;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        WAIT_LOCK
    } state_t;

endpackage

// File: rtl/pll_reconfig_responder_sync2.sv
// Two-flop synchroniser for the asynchronous PLL lock indication.
module sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/pll_reconfig_responder.sv
// Management-bus responder: shadow registers for the PLL counters, a timed
// reconfiguration sequence, atomic publication of the new settings and lock wait.
import pll_cfg_pkg::*;

module pll_reconfig_responder #(
    parameter int RECONF_CYCLES = 64,
    parameter int LOCK_TIMEOUT  = 4096
) (
    input  logic        mgmt_clk,
    input  logic        mgmt_reset_n,
    input  logic [5:0]  mgmt_address,
    input  logic        mgmt_write,
    input  logic [31:0] mgmt_writedata,
    input  logic        mgmt_read,
    output logic [31:0] mgmt_readdata,
    output logic        mgmt_waitrequest,
    input  logic        pll_locked,
    output logic [31:0] pll_n,
    output logic [31:0] pll_m,
    output logic [31:0] pll_c0,
    output logic [31:0] pll_mfrac,
    output logic        reconf_strobe,
    output logic        reconf_busy
);

    localparam logic [31:0] RECONF_LOAD = 32'(RECONF_CYCLES - 1);
    localparam logic [31:0] LOCK_LOAD   = 32'(LOCK_TIMEOUT - 1);

    state_t      state, state_next;
    logic [31:0] cnt, cnt_next;
    logic        lock_err, err_next;
    logic        apply;
    logic        locked_sync;

    logic        poll_mode;
    logic [31:0] n_shadow, m_shadow, c0_shadow, mfrac_shadow;
    logic        rd_phase;
    logic [31:0] rd_mux;

    logic        stall, wr_acc, start_acc, rd_capture;

    sync2 u_lock_sync (
        .clk   (mgmt_clk),
        .rst_n (mgmt_reset_n),
        .d     (pll_locked),
        .q     (locked_sync)
    );

    // In waitrequest mode any request outside IDLE is held off without side effects.
    assign stall      = !poll_mode && (state != IDLE) && (mgmt_read || mgmt_write);
    assign wr_acc     = mgmt_write && !stall;
    assign start_acc  = wr_acc && (mgmt_address == ADDR_START) && (state == IDLE);
    assign rd_capture = mgmt_read && !mgmt_write && !stall && !rd_phase;

    assign mgmt_waitrequest = mgmt_reset_n && (stall || (mgmt_read && !mgmt_write && !rd_phase));
    assign reconf_busy      = (state != IDLE);

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        err_next   = lock_err;
        apply      = 1'b0;
        case (state)
            IDLE: begin
                if (start_acc) begin
                    err_next   = 1'b0;
                    cnt_next   = RECONF_LOAD;
                    state_next = BUSY;
                end
            end
            BUSY: begin
                if (cnt == '0) begin
                    apply      = 1'b1;
                    cnt_next   = LOCK_LOAD;
                    state_next = WAIT_LOCK;
                end else begin
                    cnt_next = cnt - 32'd1;
                end
            end
            WAIT_LOCK: begin
                if (locked_sync) begin
                    state_next = IDLE;
                end else if (cnt == '0) begin
                    err_next   = 1'b1;
                    state_next = IDLE;
                end else begin
                    cnt_next = cnt - 32'd1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        rd_mux = '0;
        case (mgmt_address)
            ADDR_MODE:   rd_mux = {31'd0, poll_mode};
            ADDR_STATUS: rd_mux = {30'd0, lock_err, state == IDLE};
            ADDR_N:      rd_mux = n_shadow;
            ADDR_M:      rd_mux = m_shadow;
            ADDR_C0:     rd_mux = c0_shadow;
            ADDR_MFRAC:  rd_mux = mfrac_shadow;
            default:     rd_mux = '0;
        endcase
    end

    // NOTE: all registers here are plain flops, so each takes its value on asynchronous reset.
    always_ff @(posedge mgmt_clk or negedge mgmt_reset_n) begin
        if (!mgmt_reset_n) begin
            state         <= IDLE;
            cnt           <= '0;
            lock_err      <= 1'b0;
            reconf_strobe <= 1'b0;
            pll_n         <= N_RESET;
            pll_m         <= M_RESET;
            pll_c0        <= C0_RESET;
            pll_mfrac     <= MFRAC_RESET;
        end else begin
            state         <= state_next;
            cnt           <= cnt_next;
            lock_err      <= err_next;
            reconf_strobe <= apply;
            if (apply) begin
                pll_n     <= n_shadow;
                pll_m     <= m_shadow;
                pll_c0    <= c0_shadow;
                pll_mfrac <= mfrac_shadow;
            end
        end
    end

    always_ff @(posedge mgmt_clk or negedge mgmt_reset_n) begin
        if (!mgmt_reset_n) begin
            poll_mode     <= 1'b0;
            n_shadow      <= N_RESET;
            m_shadow      <= M_RESET;
            c0_shadow     <= C0_RESET;
            mfrac_shadow  <= MFRAC_RESET;
            rd_phase      <= 1'b0;
            mgmt_readdata <= '0;
        end else begin
            rd_phase <= rd_capture;
            if (rd_capture) begin
                mgmt_readdata <= rd_mux;
            end
            if (wr_acc) begin
                case (mgmt_address)
                    ADDR_MODE:  poll_mode    <= mgmt_writedata[0];
                    ADDR_N:     n_shadow     <= mgmt_writedata;
                    ADDR_M:     m_shadow     <= mgmt_writedata;
                    ADDR_C0:    c0_shadow    <= mgmt_writedata;
                    ADDR_MFRAC: mfrac_shadow <= mgmt_writedata;
                    default:    ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pll_reconfig_responder.sv
// Directed bench for pll_reconfig_responder; read data and strobe events are
// checked by a monitor against expectations queued by the stimulus.
module tb_pll_reconfig_responder;

    localparam int RC = 8;
    localparam int LT = 20;

    typedef struct {
        int          cyc;
        logic [31:0] n;
        logic [31:0] m;
        logic [31:0] c0;
        logic [31:0] mfrac;
    } strobe_exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [5:0]  address;
    logic        write;
    logic [31:0] writedata;
    logic        read;
    logic [31:0] readdata;
    logic        waitrequest;
    logic        locked;
    logic [31:0] pll_n, pll_m, pll_c0, pll_mfrac;
    logic        strobe, busy;

    int          cyc = 0;
    int          pass_cnt = 0;
    int          total_cnt = 0;
    int          unexp_reads = 0;
    int          unexp_strobes = 0;
    logic [31:0] rd_q[$];
    strobe_exp_t strobe_q[$];

    pll_reconfig_responder #(.RECONF_CYCLES(RC), .LOCK_TIMEOUT(LT)) dut (
        .mgmt_clk         (clk),
        .mgmt_reset_n     (rst_n),
        .mgmt_address     (address),
        .mgmt_write       (write),
        .mgmt_writedata   (writedata),
        .mgmt_read        (read),
        .mgmt_readdata    (readdata),
        .mgmt_waitrequest (waitrequest),
        .pll_locked       (locked),
        .pll_n            (pll_n),
        .pll_m            (pll_m),
        .pll_c0           (pll_c0),
        .pll_mfrac        (pll_mfrac),
        .reconf_strobe    (strobe),
        .reconf_busy      (busy)
    );

    always #10 clk = ~clk;
    always @(posedge clk) cyc = cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    always @(negedge clk) begin : monitor
        logic [31:0] e;
        strobe_exp_t se;
        if (rst_n && read && !write && !waitrequest) begin
            if (rd_q.size() > 0) begin
                e = rd_q.pop_front();
                check("read_data", readdata, e);
            end else begin
                unexp_reads++;
            end
        end
        if (strobe) begin
            if (strobe_q.size() > 0) begin
                se = strobe_q.pop_front();
                check("strobe_cycle", 32'(cyc), 32'(se.cyc));
                check("strobe_pll_n", pll_n, se.n);
                check("strobe_pll_m", pll_m, se.m);
                check("strobe_pll_c0", pll_c0, se.c0);
                check("strobe_pll_mfrac", pll_mfrac, se.mfrac);
            end else begin
                unexp_strobes++;
            end
        end
    end

    task automatic bus_write(input logic [5:0] a, input logic [31:0] d, output int waits);
        waits = 0;
        address = a; writedata = d; write = 1'b1;
        forever begin
            @(negedge clk);
            if (!waitrequest) break;
            waits++;
            if (waits > 200) break;
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        write = 1'b0;
    endtask

    task automatic bus_read(input logic [5:0] a, input logic [31:0] exp, output int waits);
        waits = 0;
        rd_q.push_back(exp);
        address = a; read = 1'b1;
        forever begin
            @(negedge clk);
            if (!waitrequest) break;
            waits++;
            if (waits > 200) break;
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        read = 1'b0;
    endtask

    task automatic wait_idle(output int cycles);
        cycles = 0;
        do begin
            @(negedge clk);
            cycles++;
        end while (busy && cycles < 200);
        @(posedge clk); #1;
    endtask

    task automatic push_strobe(input int c, input logic [31:0] n, input logic [31:0] m,
                               input logic [31:0] c0, input logic [31:0] mf);
        strobe_exp_t se;
        se.cyc = c; se.n = n; se.m = m; se.c0 = c0; se.mfrac = mf;
        strobe_q.push_back(se);
    endtask

    initial begin
        int w;
        int t;
        int x;
        rst_n = 1'b0; address = '0; write = 1'b0; writedata = '0; read = 1'b0; locked = 1'b0;
        #25;
        check("rst_pll_n", pll_n, 32'h0001_0000);
        check("rst_pll_m", pll_m, 32'h0000_0404);
        check("rst_pll_c0", pll_c0, 32'h0000_0505);
        check("rst_pll_mfrac", pll_mfrac, 32'h9745_BF27);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_readdata", readdata, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        bus_read(6'd3, 32'h0001_0000, w); check("rd_n_waits", 32'(w), 32'd1);
        bus_read(6'd4, 32'h0000_0404, w); check("rd_m_waits", 32'(w), 32'd1);
        bus_read(6'd5, 32'h0000_0505, w); check("rd_c0_waits", 32'(w), 32'd1);
        bus_read(6'd7, 32'h9745_BF27, w); check("rd_mfrac_waits", 32'(w), 32'd1);
        bus_read(6'd2, 32'h0000_0000, w);

        // PAL sequence with lock held high
        locked = 1'b1;
        bus_write(6'd0, 32'd0, w);          check("wr_mode_waits", 32'(w), 32'd0);
        bus_write(6'd5, 32'h0002_0504, w);  check("wr_c0_waits", 32'(w), 32'd0);
        bus_write(6'd7, 32'hA3D7_09E8, w);  check("wr_mfrac_waits", 32'(w), 32'd0);
        bus_write(6'd2, 32'd0, w);
        t = cyc;
        check("busy_after_start", {31'd0, busy}, 32'd1);
        push_strobe(t + RC, 32'h0001_0000, 32'h0000_0404, 32'h0002_0504, 32'hA3D7_09E8);
        wait_idle(w);
        bus_read(6'd1, 32'h1, w);

        // waitrequest mode: N write during BUSY stalls until IDLE
        bus_write(6'd2, 32'd0, w);
        t = cyc;
        push_strobe(t + RC, 32'h0001_0000, 32'h0000_0404, 32'h0002_0504, 32'hA3D7_09E8);
        bus_write(6'd3, 32'h0003_0000, w);
        check("wr_stall_cycles", 32'(w), 32'(RC + 1));
        check("busy_after_stall", {31'd0, busy}, 32'd0);
        check("pll_n_unchanged", pll_n, 32'h0001_0000);
        bus_read(6'd3, 32'h0003_0000, w);

        // polling mode: second start during BUSY is ignored
        bus_write(6'd0, 32'd1, w);
        bus_write(6'd2, 32'd0, w);
        t = cyc;
        push_strobe(t + RC, 32'h0003_0000, 32'h0000_0404, 32'h0002_0504, 32'hA3D7_09E8);
        bus_write(6'd2, 32'd0, w);          check("poll_start_waits", 32'(w), 32'd0);
        bus_read(6'd1, 32'h0, w);
        wait_idle(w);
        bus_read(6'd1, 32'h1, w);

        // lock never arrives: timeout sets the sticky error
        locked = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        bus_write(6'd2, 32'd0, w);
        t = cyc;
        push_strobe(t + RC, 32'h0003_0000, 32'h0000_0404, 32'h0002_0504, 32'hA3D7_09E8);
        x = 0;
        do begin @(negedge clk); x++; end while (busy && x < 200);
        check("timeout_cycle", 32'(cyc - t), 32'(RC + LT));
        @(posedge clk); #1;
        bus_read(6'd1, 32'h3, w);

        // next start clears the error; late lock returns to IDLE in 3 cycles
        bus_write(6'd2, 32'd0, w);
        t = cyc;
        push_strobe(t + RC, 32'h0003_0000, 32'h0000_0404, 32'h0002_0504, 32'hA3D7_09E8);
        repeat (RC + 5) begin @(posedge clk); #1; end
        locked = 1'b1;
        x = cyc;
        t = 0;
        do begin @(negedge clk); t++; end while (busy && t < 200);
        check("lock_to_idle", 32'(cyc - x), 32'd3);
        @(posedge clk); #1;
        bus_read(6'd1, 32'h1, w);

        // asynchronous reset in the middle of BUSY
        bus_write(6'd0, 32'd0, w);
        bus_write(6'd3, 32'h0000_0055, w);
        bus_write(6'd2, 32'd0, w);
        repeat (3) begin @(posedge clk); #1; end
        #4 rst_n = 1'b0;
        #1;
        check("arst_pll_n", pll_n, 32'h0001_0000);
        check("arst_pll_c0", pll_c0, 32'h0000_0505);
        check("arst_pll_mfrac", pll_mfrac, 32'h9745_BF27);
        check("arst_busy", {31'd0, busy}, 32'd0);
        check("arst_strobe", {31'd0, strobe}, 32'd0);
        check("arst_waitreq", {31'd0, waitrequest}, 32'd0);
        check("arst_readdata", readdata, 32'd0);
        #5 rst_n = 1'b1;
        repeat (2 * RC) begin @(posedge clk); #1; end
        check("post_rst_busy", {31'd0, busy}, 32'd0);
        bus_read(6'd3, 32'h0001_0000, w);
        bus_read(6'd1, 32'h1, w);
        repeat (4) begin @(posedge clk); #1; end

        check("unexpected_strobes", 32'(unexp_strobes), 32'd0);
        check("strobe_q_left", 32'(strobe_q.size()), 32'd0);
        check("unexpected_reads", 32'(unexp_reads), 32'd0);
        check("read_q_left", 32'(rd_q.size()), 32'd0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
